// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: bundles the arbiter's request, multiplexer-control and
// downstream valid/ready signals. The arbiter connects through the slave
// modport; the surrounding logic (requesters, multiplexer, consumer)
// connects through the master modport.
// Bit numbering follows the multiplexer: index 0 is the leftmost bit.

interface rr_arbiter_8_if;
  logic [0:7]  req;
  logic [0:2]  mux_sel;
  logic        mux_enb;
  logic [0:31] mux_y;
  logic [0:7]  grant;
  logic [0:31] out_data;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  req,
    input  mux_y,
    input  out_ready,
    output mux_sel,
    output mux_enb,
    output grant,
    output out_data,
    output out_valid
  );

  modport master (
    output req,
    output mux_y,
    output out_ready,
    input  mux_sel,
    input  mux_enb,
    input  grant,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way arbiter and capture stage in front of the 8-to-1
// word multiplexer. In IDLE it picks a requester and drives the
// multiplexer's sel/enb. In SELECT it captures the multiplexer output. In
// HOLD it presents the word downstream until the consumer takes it.
//
// Configuration macro: RR_ARBITER_FIXED_PRIO_EN
//   undefined (default): round-robin. The scan starts one past the last
//                        granted source.
//   defined            : fixed priority. The lowest requesting index always
//                        wins, and no last-grant pointer is kept.

module rr_arbiter_8 (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter_8_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [0:2]  mux_sel_q, mux_sel_d;
  logic        mux_enb_q, mux_enb_d;
  logic [0:7]  grant_q, grant_d;
  logic [0:31] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  winner;

`ifndef RR_ARBITER_FIXED_PRIO_EN
  logic [2:0]  ptr_q, ptr_d;
`endif

`ifdef RR_ARBITER_FIXED_PRIO_EN
  // Fixed priority: walk from the highest index down, so the lowest set index is the last one written.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[i]) begin
        winner = 3'(i);
      end
    end
  end
`else
  // Round-robin: walk the scan order ptr+1 .. ptr+8 backwards, so the first requester in that order is the last one written.
  always_comb begin
    winner = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (bus.req[3'(ptr_q + 3'(k))]) begin
        winner = 3'(ptr_q + 3'(k));
      end
    end
  end
`endif

  // Next-state logic. grant defaults to 0 so that it pulses for exactly one cycle after the capture.
  always_comb begin
    state_d     = state_q;
    mux_sel_d   = mux_sel_q;
    mux_enb_d   = mux_enb_q;
    grant_d     = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifndef RR_ARBITER_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          mux_sel_d = winner;
          mux_enb_d = 1'b1;
          state_d   = SELECT;
        end
      end
      SELECT: begin
        out_data_d         = bus.mux_y;
        out_valid_d        = 1'b1;
        grant_d[mux_sel_q] = 1'b1;
        mux_enb_d          = 1'b0;
`ifndef RR_ARBITER_FIXED_PRIO_EN
        ptr_d              = mux_sel_q;
`endif
        state_d            = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered FSM state and outputs. ptr resets to 7 so that the first scan begins at source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_sel_q   <= '0;
      mux_enb_q   <= 1'b0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifndef RR_ARBITER_FIXED_PRIO_EN
      ptr_q       <= 3'd7;
`endif
    end else begin
      state_q     <= state_d;
      mux_sel_q   <= mux_sel_d;
      mux_enb_q   <= mux_enb_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifndef RR_ARBITER_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.mux_enb   = mux_enb_q;
  assign bus.grant     = grant_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for rr_arbiter_8. The stimulus process
// runs transfers and pushes the word it expects, computed from a simple
// arbitration model. A separate monitor pops that word when out_valid rises
// and checks it, then checks that the word stays stable while held.
// Define RR_ARBITER_FIXED_PRIO_EN to check the fixed-priority build.
`timescale 1ns/1ps

module tb_rr_arbiter_8;

  typedef struct {
    int unsigned winner;
    logic [0:31] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [0:31] mux_in [8];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned ptr_m;
  int          tests;
  int          failures;
  logic        valid_prev;
  logic [0:31] held_data;
  logic [0:2]  held_sel;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational 8-to-1 word multiplexer with an enable; outputs 0 when disabled.
  always_comb begin
    bus.mux_y = bus.mux_enb ? mux_in[bus.mux_sel] : 32'h0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration: the first requester after the last grant, or the lowest index in the fixed build.
  function automatic int unsigned model_winner(logic [0:7] r, int unsigned p);
`ifdef RR_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) begin
      if (r[i]) return i;
    end
`else
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
`endif
    return 0;
  endfunction

  function automatic logic [0:7] one_hot(int unsigned w);
    logic [0:7] g;
    g = '0;
    g[w] = 1'b1;
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one transfer. The caller sits at a negedge with the DUT in IDLE.
  task automatic applyStimulus(input logic [0:7] r, input int stall, input bit scramble);
    exp_t        e;
    int unsigned w;
    w = model_winner(r, ptr_m);
    ptr_m = w;
    e.winner = w;
    e.data   = mux_in[w];
    exp_q.push_back(e);
    bus.req       = r;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (scramble) bus.req = 8'($urandom);
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.req       = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mux_sel"},   32'(bus.mux_sel),   32'h0);
    checkOutput({tag, "_mux_enb"},   32'(bus.mux_enb),   32'h0);
    checkOutput({tag, "_grant"},     32'(bus.grant),     32'h0);
    checkOutput({tag, "_out_data"},  32'(bus.out_data),  32'h0);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
  endtask

  // Monitor: pop and check each new word, then check stability and quiet control outputs while it is held.
  always @(negedge clk) begin
    if (bus.out_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_word: got data %0h with nothing pending at %0t", bus.out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("grant",    32'(bus.grant),   32'(one_hot(mon_e.winner)));
        checkOutput("out_data", 32'(bus.out_data), 32'(mon_e.data));
        checkOutput("mux_sel",  32'(bus.mux_sel), mon_e.winner);
        held_data = mon_e.data;
        held_sel  = 3'(mon_e.winner);
      end
    end else if (bus.out_valid) begin
      checkOutput("hold_data",  32'(bus.out_data), 32'(held_data));
      checkOutput("hold_grant", 32'(bus.grant),    32'h0);
      checkOutput("hold_enb",   32'(bus.mux_enb),  32'h0);
      checkOutput("hold_sel",   32'(bus.mux_sel),  32'(held_sel));
    end else begin
      checkOutput("idle_grant", 32'(bus.grant), 32'h0);
    end
    valid_prev = bus.out_valid;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failures=%0d", tests, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [0:7] r;
    tests         = 0;
    failures      = 0;
    valid_prev    = 1'b0;
    held_data     = '0;
    held_sel      = '0;
    ptr_m         = 7;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mux_in[i] = 32'(32'h010101 * (i + 1));

    #3;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester: source 3 with a3 = 32'h040404.
    applyStimulus(8'b0001_0000, 0, 1'b0);

    // Reset asserted mid-HOLD: outputs clear at once and the pending word is dropped.
    bus.req = 8'b0000_0010;
    exp_q.push_back('{winner: model_winner(8'b0000_0010, ptr_m), data: mux_in[model_winner(8'b0000_0010, ptr_m)]});
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("midhold_reset");
    ptr_m = 7;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("post_reset_enb",   32'(bus.mux_enb),   32'h0);

    // Fairness: all sources requesting, nine transfers.
    for (int i = 0; i < 9; i++) applyStimulus(8'hFF, 0, 1'b0);

    // Wrap and skip: grant 5, then bits 0 and 5 requesting.
    applyStimulus(8'b0000_0100, 0, 1'b0);
    applyStimulus(8'b1000_0100, 0, 1'b0);
    applyStimulus(8'b1000_0100, 0, 1'b0);

    // Backpressure: five stalled cycles after the capture.
    applyStimulus(8'b0010_0000, 5, 1'b0);

    // Lone requester re-granted while it is the last granted source.
    applyStimulus(8'b0010_0000, 1, 1'b1);

    // Randomized transfers with idle gaps, stalls and requests scrambled after sampling.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 8; i++) mux_in[i] = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = 8'($urandom);
      if (r == '0) r[$urandom_range(0, 7)] = 1'b1;
      applyStimulus(r, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
